// File: rtl/prog_dumper_pkg.sv
// ---------------------------------------------------------------------------
// prog_dumper_pkg
// Shared definitions for the program dumper and its companion loader:
// sequencing state encoding, UART frame width, bus widths and the wrapping
// address increment.
// ---------------------------------------------------------------------------
package prog_dumper_pkg;

    localparam int unsigned ADR_W           = 21;
    localparam int unsigned LEN_W           = 22;
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAITCTS = 3'd2,
        ST_FRAME   = 3'd3,
        ST_SUM     = 3'd4,
        ST_FIN     = 3'd5
    } dump_state_t;

    // 0x1FFFFF rolls over to 0x000000 through the natural 21-bit wrap.
    function automatic logic [ADR_W-1:0] adr_inc(input logic [ADR_W-1:0] a);
        return a + ADR_W'(1);
    endfunction

endpackage

// File: rtl/prog_dumper_uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx_8n1
// UART 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each
// bit held for BAUD_DIV clk cycles.
//
// Ports:
//   clk        system clock (gbclk)
//   reset      synchronous, active-high; forces tx high and drops any frame
//   load       start a frame with data_byte (taken only while ready)
//   data_byte  byte to send
//   tx         serial line, idle high, registered
//   ready      high when idle or during the final clk of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_8n1
    import prog_dumper_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_byte,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned     BAUD_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(UART_FRAME_BITS - 1);

    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [8:0]        data_sr;
    logic              active;
    logic              baud_tc;
    logic              last_tick;

    assign baud_tc   = (baud_cnt == '0);
    // bit_cnt counts down the frame: 9 = start bit ... 0 = stop bit.
    assign last_tick = active && baud_tc && (bit_cnt == '0);
    // Ready in the final stop-bit cycle so the sequencer can leave FRAME on
    // the same edge that ends the stop bit.
    assign ready     = !active || last_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            data_sr  <= '1;
        end else if (load && ready) begin
            tx       <= 1'b0;
            active   <= 1'b1;
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= BIT_LAST;
            data_sr  <= {1'b1, data_byte};
        end else if (active) begin
            if (baud_tc) begin
                baud_cnt <= BAUD_LAST;
                if (bit_cnt == '0) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    // Stop bit shifts in behind the data, so it falls out last.
                    bit_cnt <= bit_cnt - 4'd1;
                    tx      <= data_sr[0];
                    data_sr <= {1'b1, data_sr[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt - BAUD_W'(1);
            end
        end
    end

endmodule

// File: rtl/prog_dumper.sv
// ---------------------------------------------------------------------------
// prog_dumper
// Reads a range of the 21-bit external address space while the GB core is
// held in reset and streams each byte out as UART 8N1, optionally followed
// by a mod-256 checksum byte.
//
// Ports:
//   clk        system clock (gbclk)
//   reset      synchronous, active-high; aborts any transfer
//   start      one-cycle pulse, accepted only in IDLE
//   start_adr  first address to dump
//   len        byte count, 0..2^21
//   cts        host ready; sampled only before each frame's start bit
//   adr/read   external bus address and read strobe
//   din        external bus read data
//   tx         UART TX line, idle high
//   busy       transfer in progress
//   done       one-cycle pulse after the last frame's stop bit
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// READ    | read held READ_LAT cycles, din captured on the last one
// WAITCTS | byte ready, waiting for the host to accept a frame
// FRAME   | UART frame in flight
// SUM     | checksum loaded as the next byte, no bus access
// FIN     | issue done, drop busy
// ---------------------------------------------------------------------------
module prog_dumper
    import prog_dumper_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 36,
    parameter int unsigned READ_LAT = 2,
    parameter int unsigned SEND_SUM = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] start_adr,
    input  logic [21:0] len,
    input  logic        cts,
    output logic [20:0] adr,
    output logic        read,
    input  logic [7:0]  din,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);
    localparam bit         SUM_EN   = (SEND_SUM != 0);

    dump_state_t      state, state_nxt;
    logic [ADR_W-1:0] cur_adr, cur_adr_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic [7:0]       sum, sum_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [3:0]       lat_cnt, lat_nxt;
    logic             is_sum, is_sum_nxt;
    logic [ADR_W-1:0] adr_nxt;
    logic             read_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             uart_load;
    logic             tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur_adr   <= '0;
            remaining <= '0;
            sum       <= '0;
            shreg     <= '0;
            lat_cnt   <= '0;
            is_sum    <= 1'b0;
            adr       <= '0;
            read      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_adr   <= cur_adr_nxt;
            remaining <= remaining_nxt;
            sum       <= sum_nxt;
            shreg     <= shreg_nxt;
            lat_cnt   <= lat_nxt;
            is_sum    <= is_sum_nxt;
            adr       <= adr_nxt;
            read      <= read_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Bus outputs are registered, so read/adr are set up on the transition
    // into READ rather than from inside it.
    always_comb begin
        state_nxt     = state;
        cur_adr_nxt   = cur_adr;
        remaining_nxt = remaining;
        sum_nxt       = sum;
        shreg_nxt     = shreg;
        lat_nxt       = lat_cnt;
        is_sum_nxt    = is_sum;
        adr_nxt       = adr;
        read_nxt      = 1'b0;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        uart_load     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    cur_adr_nxt   = start_adr;
                    remaining_nxt = len;
                    sum_nxt       = '0;
                    is_sum_nxt    = 1'b0;
                    busy_nxt      = 1'b1;
                    if (len == '0) begin
                        state_nxt = SUM_EN ? ST_SUM : ST_FIN;
                    end else begin
                        state_nxt = ST_READ;
                        read_nxt  = 1'b1;
                        adr_nxt   = start_adr;
                        lat_nxt   = LAT_LAST;
                    end
                end
            end
            ST_READ: begin
                if (lat_cnt == '0) begin
                    shreg_nxt = din;
                    sum_nxt   = sum + din;
                    state_nxt = ST_WAITCTS;
                end else begin
                    lat_nxt  = lat_cnt - 4'd1;
                    read_nxt = 1'b1;
                end
            end
            ST_WAITCTS: begin
                if (cts) begin
                    uart_load = 1'b1;
                    state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (tx_ready) begin
                    if (is_sum) begin
                        state_nxt = ST_FIN;
                    end else begin
                        remaining_nxt = remaining - LEN_W'(1);
                        cur_adr_nxt   = adr_inc(cur_adr);
                        if (remaining_nxt == '0) begin
                            state_nxt = SUM_EN ? ST_SUM : ST_FIN;
                        end else begin
                            state_nxt = ST_READ;
                            read_nxt  = 1'b1;
                            adr_nxt   = cur_adr_nxt;
                            lat_nxt   = LAT_LAST;
                        end
                    end
                end
            end
            ST_SUM: begin
                shreg_nxt  = sum;
                is_sum_nxt = 1'b1;
                state_nxt  = ST_WAITCTS;
            end
            ST_FIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    uart_tx_8n1 #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (uart_load),
        .data_byte (shreg),
        .tx        (tx),
        .ready     (tx_ready)
    );

endmodule

// File: tb/tb_prog_dumper.sv
// ---------------------------------------------------------------------------
// tb_prog_dumper
// Two dumpers share the stimulus: dut_s0 without checksum, dut_s1 with it.
// 'sel' picks which one receives start and which one the monitors watch.
// The expected byte stream and read addresses come from a plain model of
// the dump: bytes of memory from start_adr for len bytes, plus their sum.
// ---------------------------------------------------------------------------
module tb_prog_dumper;

    localparam int BAUD      = 4;
    localparam int RLAT      = 2;
    localparam int FRAME_CYC = 10 * BAUD;

    logic        clk = 1'b0;
    logic        reset, start, cts, sel, cts_rand;
    logic [20:0] start_adr;
    logic [21:0] len;
    logic        start0, start1;
    logic [20:0] adr0, adr1, adr_m;
    logic        read0, read1, read_m;
    logic        tx0, tx1, tx_m;
    logic        busy0, busy1, busy_m;
    logic        done0, done1, done_m;
    logic [7:0]  din0, din1;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(input logic [20:0] a);
        case (a)
            21'h000010: return 8'hA5;
            21'h000100: return 8'h80;
            21'h000101: return 8'h90;
            21'h000102: return 8'h01;
            default:    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
        endcase
    endfunction

    assign start0 = start & ~sel;
    assign start1 = start & sel;
    assign din0   = mem_val(adr0);
    assign din1   = mem_val(adr1);
    assign adr_m  = sel ? adr1  : adr0;
    assign read_m = sel ? read1 : read0;
    assign tx_m   = sel ? tx1   : tx0;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;

    prog_dumper #(.BAUD_DIV(BAUD), .READ_LAT(RLAT), .SEND_SUM(0)) dut_s0 (
        .clk(clk), .reset(reset), .start(start0), .start_adr(start_adr), .len(len),
        .cts(cts), .adr(adr0), .read(read0), .din(din0), .tx(tx0), .busy(busy0), .done(done0)
    );

    prog_dumper #(.BAUD_DIV(BAUD), .READ_LAT(RLAT), .SEND_SUM(1)) dut_s1 (
        .clk(clk), .reset(reset), .start(start1), .start_adr(start_adr), .len(len),
        .cts(cts), .adr(adr1), .read(read1), .din(din1), .tx(tx1), .busy(busy1), .done(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors (sampled on the falling edge) ----------------
    int          cyc = 0;
    bit          rx_act = 0;
    int          rx_n = 0;
    logic        rx_smp [FRAME_CYC];
    bit          rx_ok;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_q[$];
    int          fs_q[$];
    int          fe_q[$];
    int          last_stop = 0;
    int          frames_run = 0;
    bit          tx_low_seen = 0;
    bit          rd_prev = 0;
    int          rd_run = 0;
    logic [20:0] rd_adr_hold;
    logic [20:0] rd_adr_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (start) start_cyc = cyc;
        if (reset) begin
            rx_act  = 0;
            rx_n    = 0;
            rd_prev = 0;
            rd_run  = 0;
        end else begin
            if (tx_m == 1'b0) tx_low_seen = 1;
            if (!rx_act && tx_m == 1'b0) begin
                rx_act = 1;
                rx_n   = 0;
                fs_q.push_back(cyc);
            end
            if (rx_act) begin
                rx_smp[rx_n] = tx_m;
                rx_n++;
                if (rx_n == FRAME_CYC) begin
                    rx_ok = 1;
                    for (int k = 0; k < 10; k++)
                        for (int j = 1; j < BAUD; j++)
                            if (rx_smp[k*BAUD+j] !== rx_smp[k*BAUD]) rx_ok = 0;
                    if (rx_smp[0] !== 1'b0 || rx_smp[9*BAUD] !== 1'b1) rx_ok = 0;
                    for (int k = 0; k < 8; k++) rx_byte[k] = rx_smp[(k+1)*BAUD];
                    check_val("frame_shape", rx_ok, 1);
                    rx_q.push_back(rx_byte);
                    fe_q.push_back(cyc);
                    last_stop = cyc;
                    frames_run++;
                    rx_act = 0;
                end
            end

            if (read_m) begin
                if (!rd_prev) begin
                    rd_adr_q.push_back(adr_m);
                    rd_adr_hold = adr_m;
                    rd_run = 1;
                end else begin
                    rd_run++;
                    check_val("adr_hold", adr_m, rd_adr_hold);
                end
            end else if (rd_prev) begin
                check_val("read_len", rd_run, RLAT);
            end
            rd_prev = read_m;

            if (done_m) begin
                done_cnt++;
                done_cyc = cyc;
                check_val("busy_at_done", busy_m, 0);
                if (frames_run > 0) check_val("done_after_stop", cyc - last_stop, 2);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cts_rand) cts = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_mon();
        rx_q.delete();
        fs_q.delete();
        fe_q.delete();
        rd_adr_q.delete();
        done_cnt    = 0;
        frames_run  = 0;
        tx_low_seen = 0;
    endtask

    task automatic wait_done(input int bound, input bit pulse2);
        for (int i = 0; i < bound && done_cnt == 0; i++) begin
            @(posedge clk);
            #1;
            if (pulse2 && i == 60) begin
                start_adr = 21'h00AAAA;
                len       = 22'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check_val("done_seen", (done_cnt > 0) ? 1 : 0, 1);
    endtask

    task automatic run_dump(input bit s, input logic [20:0] sa, input int ln, input bit pulse2);
        logic [7:0]  exp_b[$];
        logic [20:0] exp_a[$];
        logic [7:0]  acc;
        logic [20:0] a;
        int          n;
        acc = 8'h00;
        a   = sa;
        for (int i = 0; i < ln; i++) begin
            exp_a.push_back(a);
            exp_b.push_back(mem_val(a));
            acc = acc + mem_val(a);
            a   = a + 21'd1;
        end
        if (s) exp_b.push_back(acc);

        @(posedge clk);
        #1;
        sel = s;
        clear_mon();
        start_adr = sa;
        len       = 22'(ln);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_val("busy_after_start", busy_m, 1);
        wait_done(300 + 80 * ln, pulse2);
        repeat (8) @(posedge clk);
        check_val("done_count", done_cnt, 1);
        check_val("busy_end", busy_m, 0);
        check_val("frame_count", rx_q.size(), exp_b.size());
        check_val("read_bursts", rd_adr_q.size(), exp_a.size());
        n = (rx_q.size() < exp_b.size()) ? rx_q.size() : exp_b.size();
        for (int i = 0; i < n; i++) check_val("byte", rx_q[i], exp_b[i]);
        n = (rd_adr_q.size() < exp_a.size()) ? rd_adr_q.size() : exp_a.size();
        for (int i = 0; i < n; i++) check_val("read_adr", rd_adr_q[i], exp_a[i]);
    endtask

    // ---------------- main sequence ----------------
    int          cts_cyc;
    logic [7:0]  b_exp;
    logic [20:0] r_adr;
    int          r_len;
    bit          r_sel;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cts       = 1'b1;
        cts_rand  = 1'b0;
        sel       = 1'b0;
        start_adr = '0;
        len       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_tx0",   tx0,   1);
        check_val("rst_read0", read0, 0);
        check_val("rst_busy0", busy0, 0);
        check_val("rst_done0", done0, 0);
        check_val("rst_adr0",  adr0,  0);
        check_val("rst_tx1",   tx1,   1);
        check_val("rst_read1", read1, 0);
        check_val("rst_busy1", busy1, 0);
        check_val("rst_done1", done1, 0);
        check_val("rst_adr1",  adr1,  0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single byte 0xA5 from 0x10, no checksum
        run_dump(1'b0, 21'h000010, 1, 1'b0);

        // three bytes plus checksum; back-to-back data frames spaced READ_LAT+1
        run_dump(1'b1, 21'h000100, 3, 1'b0);
        if (fs_q.size() >= 3 && fe_q.size() >= 2) begin
            check_val("gap_01", fs_q[1] - fe_q[0] - 1, RLAT + 1);
            check_val("gap_12", fs_q[2] - fe_q[1] - 1, RLAT + 1);
        end

        // empty dumps
        run_dump(1'b1, 21'h000033, 0, 1'b0);
        run_dump(1'b0, 21'h000055, 0, 1'b0);
        check_val("len0_done_lat", done_cyc - start_cyc, 2);
        check_val("len0_tx_quiet", tx_low_seen, 0);

        // address wrap, with an ignored second start mid-transfer
        run_dump(1'b1, 21'h1FFFFF, 2, 1'b1);

        // cts stall, then cts dropped mid-frame
        @(posedge clk);
        #1;
        sel = 1'b0;
        clear_mon();
        cts       = 1'b0;
        start_adr = 21'h000020;
        len       = 22'd1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && !(rd_adr_q.size() == 1 && !read_m); i++) @(posedge clk);
        repeat (100) @(posedge clk);
        #1;
        check_val("stall_tx_idle", tx_low_seen, 0);
        check_val("stall_no_frame", fs_q.size(), 0);
        cts     = 1'b1;
        cts_cyc = cyc + 1;
        for (int i = 0; i < 20 && fs_q.size() == 0; i++) @(posedge clk);
        check_val("cts_to_frame", (fs_q.size() > 0) ? (fs_q[0] - cts_cyc) : -1, 1);
        repeat (12) @(posedge clk);
        #1;
        cts = 1'b0;
        wait_done(200, 1'b0);
        check_val("ctsdrop_frames", rx_q.size(), 1);
        b_exp = mem_val(21'h000020);
        if (rx_q.size() > 0) check_val("ctsdrop_byte", rx_q[0], b_exp);
        cts = 1'b1;

        // reset during data bit 3
        @(posedge clk);
        #1;
        sel = 1'b0;
        clear_mon();
        start_adr = 21'h000040;
        len       = 22'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 50 && fs_q.size() == 0; i++) @(posedge clk);
        check_val("rst_frame_started", fs_q.size(), 1);
        if (fs_q.size() > 0)
            for (int i = 0; i < 60 && cyc < fs_q[0] + 16; i++) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        b_exp = mem_val(21'h000040);
        check_val("rst_in_bit3", tx_m, b_exp[3]);
        @(negedge clk);
        check_val("rst_mid_tx",   tx_m,   1);
        check_val("rst_mid_read", read_m, 0);
        check_val("rst_mid_busy", busy_m, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (100) @(posedge clk);
        check_val("rst_no_done",  done_cnt,    0);
        check_val("rst_no_frame", rx_q.size(), 0);
        run_dump(1'b0, 21'h000040, 2, 1'b0);

        // randomized dumps with a jittering cts
        cts_rand = 1'b1;
        for (int t = 0; t < 10; t++) begin
            r_sel = ($urandom_range(0, 1) == 1);
            r_adr = 21'($urandom);
            if ($urandom_range(0, 3) == 0) r_adr = 21'h1FFFFF - 21'($urandom_range(0, 3));
            r_len = $urandom_range(0, 6);
            run_dump(r_sel, r_adr, r_len, 1'b0);
        end
        cts_rand = 1'b0;
        @(posedge clk);
        #1;
        cts = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_dumper.md
Name: prog_dumper

Overview:
- Reverse-direction companion to the UART program loader: reads a range of the 21-bit external address space (ROM/RAM) and streams each byte out as UART 8N1.
- Optionally appends a mod-256 checksum byte after the data.
- Runs while the GB core is held in reset and owns the external bus via the same adr/read muxing the loader uses.
- Single clock domain: the baud divider is derived from clk; no uart_clk.

Parameters:
- BAUD_DIV, 36, clk cycles per UART bit (4.194304 MHz / 36 ≈ 116.5 kBd); legal range 2..65535.
- READ_LAT, 2, clk cycles read is held before din is sampled; legal range 1..15.
- SEND_SUM, 1, 1 = append checksum byte after the last data byte.

Ports:
- clk  in  1  system clock (gbclk).
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- start_adr  in  21  first address to dump.
- len  in  22  number of bytes to dump; 0..2^21.
- cts  in  1  host ready; 1 = a new frame may begin.
- adr  out  21  external bus address.
- read  out  1  external read strobe.
- din  in  8  external data bus input.
- tx  out  1  UART TX line; idle high.
- busy  out  1  high from start acceptance until DONE.
- done  out  1  one-cycle pulse when the last frame's stop bit completes.

Behaviour:
- Reset values: tx=1, read=0, busy=0, done=0, adr=0, sum=0; state=IDLE.
- Reset is honoured in any state, including mid-frame. It aborts the transfer; tx returns high on the next edge with no completion of the partial frame.
- All outputs are registered.
- IDLE:
  - On start: latch cur_adr=start_adr, remaining=len, sum=0; busy=1.
  - If len==0 and SEND_SUM==0: go to FIN. If len==0 and SEND_SUM==1: go to SUM. Otherwise go to READ.
  - start while busy is ignored.
- READ:
  - adr=cur_adr, read=1 for exactly READ_LAT cycles.
  - On the last of these cycles, capture shreg=din.
  - Then read=0, sum=sum+din (8-bit wrap), go to WAITCTS.
- WAITCTS:
  - Stay while cts==0. tx stays 1, and this stall may last indefinitely.
  - When cts==1: go to FRAME.
- FRAME:
  - 10 bit periods of BAUD_DIV clk each: start bit 0, data bits LSB first, stop bit 1.
  - cts is checked only before the start bit; deasserting cts mid-frame does not truncate the frame.
  - At the end of the stop bit: if this was a data byte, remaining--, cur_adr++ (wraps 0x1FFFFF→0x000000), then:
    - remaining now 0: go to SUM if SEND_SUM, else FIN.
    - Otherwise go to READ.
  - If the frame just sent was the checksum, go to FIN.
- SUM: load shreg=sum, go to WAITCTS. No bus read is performed.
- FIN: done=1 for one cycle, busy=0, go to IDLE.
- Frame spacing: back-to-back frames are separated by READ_LAT+1 clk of idle-high (READ phase plus one WAITCTS cycle, with cts=1).
- adr holds its last driven value between reads; read is 0 outside READ.
- len=2^21 dumps the full space starting at start_adr, wrapping once.

Decomposition:
- Shared package: state encoding constants (IDLE, READ, WAITCTS, FRAME, SUM, FIN) and the UART frame width constant (10). The loader reuses these.
- Sub-module uart_tx_8n1:
  - Inputs: clk, reset, load, byte. Outputs: tx, ready.
  - Parameter: BAUD_DIV.
  - Contains the baud counter and the 4-bit bit counter.
  - prog_dumper holds the sequencing FSM, address counter, length counter and checksum.

Test Plan:
- BAUD_DIV=4, READ_LAT=2, SEND_SUM=0; memory[0x000010]=0xA5; start, start_adr=0x10, len=1, cts=1.
  → read high exactly 2 cycles with adr=0x10.
  → tx bits 0,1,0,1,0,0,1,0,1,1, each 4 clk.
  → done one cycle after the stop bit ends; busy low afterwards.
- SEND_SUM=1; memory 0x100..0x102 = 0x80,0x90,0x01; len=3.
  → frames 0x80, 0x90, 0x01, then checksum 0x11; adr sequence 0x100, 0x101, 0x102; exactly 3 read bursts.
- len=0, SEND_SUM=1 → single frame 0x00, no read pulse, done after it. len=0, SEND_SUM=0 → done 2 cycles after start, tx never drops.
- start_adr=0x1FFFFF, len=2.
  → reads at 0x1FFFFF then 0x000000.
  → second start pulse mid-transfer is ignored (frame count unchanged).
- cts=0 held for 100 clk after the first byte is read → tx stays 1 throughout; frame begins 1 cycle after cts rises. Dropping cts mid-frame → frame completes intact.
- reset asserted during data bit 3 of a frame → next edge: tx=1, read=0, busy=0; no done pulse. A fresh start afterwards dumps correctly.
